// File: rtl/circular_barrel_unshift_pipe.sv
// Three-stage pipelined circular left-rotator with valid/ready flow control; undoes a 40-bit right-rotate.
// Optional sideband tag carried alongside the data when CIRC_UNSHIFT_TAG_EN is defined.
module circular_barrel_unshift_pipe #(
  parameter int WIDTH = 40,
  parameter int AMT_W = 6
`ifdef CIRC_UNSHIFT_TAG_EN
  ,
  parameter int TAG_W = 6
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
`ifdef CIRC_UNSHIFT_TAG_EN
  input  logic [TAG_W-1:0] in_tag,
  output logic [TAG_W-1:0] out_tag,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // Amount bit k rotates by 2^k, folded into the word width so large amounts wrap.
  localparam int unsigned R0 = 1 % WIDTH;
  localparam int unsigned R1 = 2 % WIDTH;
  localparam int unsigned R2 = 4 % WIDTH;
  localparam int unsigned R3 = 8 % WIDTH;
  localparam int unsigned R4 = 16 % WIDTH;
  localparam int unsigned R5 = 32 % WIDTH;

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x, input int unsigned n);
    logic [2*WIDTH-1:0] dbl;
    dbl = {x, x} << n;
    return dbl[2*WIDTH-1:WIDTH];
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  logic [3:0]       s1_amt_q, s1_amt_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic [1:0]       s2_amt_q, s2_amt_d;
  logic             s3_valid_q, s3_valid_d;
  logic [WIDTH-1:0] s3_data_q, s3_data_d;
`ifdef CIRC_UNSHIFT_TAG_EN
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic [TAG_W-1:0] s3_tag_q, s3_tag_d;
`endif

  logic             s1_ready, s2_ready, s3_ready, in_fire;
  logic [WIDTH-1:0] s1_rot, s2_rot, s3_rot;

  // Ripple-ready: a stage can take a new word if it is empty or emptying this cycle.
  assign s3_ready = !s3_valid_q || out_ready;
  assign s2_ready = !s2_valid_q || s3_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign in_ready = rst_n && !flush && s1_ready;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    s1_rot = in_data;
    if (in_amt[0]) s1_rot = rotl(s1_rot, R0);
    if (in_amt[1]) s1_rot = rotl(s1_rot, R1);
    s2_rot = s1_data_q;
    if (s1_amt_q[0]) s2_rot = rotl(s2_rot, R2);
    if (s1_amt_q[1]) s2_rot = rotl(s2_rot, R3);
    s3_rot = s2_data_q;
    if (s2_amt_q[0]) s3_rot = rotl(s3_rot, R4);
    if (s2_amt_q[1]) s3_rot = rotl(s3_rot, R5);
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_amt_d   = s1_amt_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_amt_d   = s2_amt_q;
    s3_valid_d = s3_valid_q;
    s3_data_d  = s3_data_q;
`ifdef CIRC_UNSHIFT_TAG_EN
    s1_tag_d   = s1_tag_q;
    s2_tag_d   = s2_tag_q;
    s3_tag_d   = s3_tag_q;
`endif
    if (s1_ready) s1_valid_d = in_fire;
    if (in_fire) begin
      s1_data_d = s1_rot;
      s1_amt_d  = in_amt[5:2];
`ifdef CIRC_UNSHIFT_TAG_EN
      s1_tag_d  = in_tag;
`endif
    end
    if (s2_ready) s2_valid_d = s1_valid_q;
    if (s2_ready && s1_valid_q && !flush) begin
      s2_data_d = s2_rot;
      s2_amt_d  = s1_amt_q[3:2];
`ifdef CIRC_UNSHIFT_TAG_EN
      s2_tag_d  = s1_tag_q;
`endif
    end
    if (s3_ready) s3_valid_d = s2_valid_q;
    if (s3_ready && s2_valid_q && !flush) begin
      s3_data_d = s3_rot;
`ifdef CIRC_UNSHIFT_TAG_EN
      s3_tag_d  = s2_tag_q;
`endif
    end
    // Flush empties every stage but leaves data registers untouched.
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
      s3_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_amt_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_amt_q   <= '0;
      s3_valid_q <= 1'b0;
      s3_data_q  <= '0;
`ifdef CIRC_UNSHIFT_TAG_EN
      s1_tag_q   <= '0;
      s2_tag_q   <= '0;
      s3_tag_q   <= '0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_amt_q   <= s1_amt_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_amt_q   <= s2_amt_d;
      s3_valid_q <= s3_valid_d;
      s3_data_q  <= s3_data_d;
`ifdef CIRC_UNSHIFT_TAG_EN
      s1_tag_q   <= s1_tag_d;
      s2_tag_q   <= s2_tag_d;
      s3_tag_q   <= s3_tag_d;
`endif
    end
  end

  assign out_valid = s3_valid_q;
  assign out_data  = s3_data_q;
`ifdef CIRC_UNSHIFT_TAG_EN
  assign out_tag   = s3_tag_q;
`endif

endmodule

// File: tb/tb_circular_barrel_unshift_pipe.sv
// Directed and randomised self-checking bench for circular_barrel_unshift_pipe.
// Tag sequencing is exercised only when CIRC_UNSHIFT_TAG_EN is defined.
module tb_circular_barrel_unshift_pipe;
  localparam int WIDTH = 40;
  localparam int AMT_W = 6;
`ifdef CIRC_UNSHIFT_TAG_EN
  localparam int TAG_W = 6;
  logic [TAG_W-1:0] in_tag, out_tag;
`endif

  logic             clk = 1'b0;
  logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in_data, out_data;
  logic [AMT_W-1:0] in_amt;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  circular_barrel_unshift_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
`ifdef CIRC_UNSHIFT_TAG_EN
    .in_tag    (in_tag),
    .out_tag   (out_tag),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  function automatic logic [WIDTH-1:0] rotl_model(input logic [WIDTH-1:0] x, input logic [AMT_W-1:0] a);
    logic [WIDTH-1:0] r;
    int n;
    n = int'(a) % WIDTH;
    for (int i = 0; i < WIDTH; i++) r[(i + n) % WIDTH] = x[i];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rotr_model(input logic [WIDTH-1:0] x, input logic [AMT_W-1:0] a);
    logic [WIDTH-1:0] r;
    int n;
    n = int'(a) % WIDTH;
    for (int i = 0; i < WIDTH; i++) r[i] = x[(i + n) % WIDTH];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pushes one word through an otherwise idle pipe and reports its latency in cycles.
  task automatic send_one(input logic [WIDTH-1:0] d, input logic [AMT_W-1:0] a,
                          output int lat, output logic [WIDTH-1:0] got);
    int waits;
    in_data = d;
    in_amt = a;
    in_valid = 1'b1;
    out_ready = 1'b1;
    flush = 1'b0;
    waits = 0;
    #1;
    while (!in_ready && waits < 10) begin
      tick();
      waits++;
    end
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    got = out_data;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
    else passed++;
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    else passed++;
    checks++;
    if (out_data !== 40'h0) $display("[TB] FAIL reset_out_data: got %h expected 0", out_data);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL release_in_ready: got %b expected 1", in_ready);
    else passed++;
    tick();
  endtask

  task automatic test_basic_rotate();
    logic [WIDTH-1:0] vd [5] = '{40'h00_0000_0001, 40'h00_0000_0001, 40'h00_0000_0001,
                                 40'h00_0000_0001, 40'hA5_5A5A_A55A};
    logic [AMT_W-1:0] va [5] = '{6'd1, 6'd39, 6'd40, 6'd63, 6'd0};
    logic [WIDTH-1:0] ve [5] = '{40'h00_0000_0002, 40'h80_0000_0000, 40'h00_0000_0001,
                                 40'h00_0080_0000, 40'hA5_5A5A_A55A};
    int lat;
    logic [WIDTH-1:0] got;
    for (int i = 0; i < 5; i++) begin
      send_one(vd[i], va[i], lat, got);
      checks++;
      if (lat != 3) $display("[TB] FAIL basic_latency[%0d]: got %0d expected 3", i, lat);
      else passed++;
      checks++;
      if (got !== ve[i]) $display("[TB] FAIL basic_data[%0d]: got %h expected %h", i, got, ve[i]);
      else passed++;
    end
  endtask

  task automatic test_round_trip();
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] orig, expv;
    logic have_pend;
    int sent, got, stalls, cyc;
    sent = 0; got = 0; stalls = 0; cyc = 0; have_pend = 1'b0; orig = '0;
    out_ready = 1'b1;
    while (got < 1000 && cyc < 1100) begin
      if (sent < 1000) begin
        if (!have_pend) begin
          orig = {8'($urandom), 32'($urandom)};
          in_amt = 6'($urandom);
          in_data = rotr_model(orig, in_amt);
          have_pend = 1'b1;
        end
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 40'hx;
        checks++;
        if (out_data !== expv) $display("[TB] FAIL round_trip[%0d]: got %h expected %h", got, out_data, expv);
        else passed++;
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(orig);
        sent++;
        have_pend = 1'b0;
      end else if (in_valid) begin
        stalls++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 1000) $display("[TB] FAIL round_trip_count: got %0d expected 1000", got);
    else passed++;
    checks++;
    if (stalls != 0) $display("[TB] FAIL round_trip_stalls: got %0d expected 0", stalls);
    else passed++;
    checks++;
    if (cyc != 1003) $display("[TB] FAIL round_trip_cycles: got %0d expected 1003", cyc);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] vd [5] = '{40'h1, 40'h2, 40'h3, 40'h4, 40'hF0_0000_0001};
    logic [AMT_W-1:0] va [5] = '{6'd0, 6'd4, 6'd8, 6'd12, 6'd44};
    logic [WIDTH-1:0] ve [5] = '{40'h1, 40'h20, 40'h300, 40'h4000, 40'h1F};
    int w, rcv, cyc;
    logic stable;
    w = 0; rcv = 0; cyc = 0; stable = 1'b1;
    while (rcv < 5 && cyc < 40) begin
      out_ready = (cyc >= 6);
      in_valid = (w < 5);
      in_data = (w < 5) ? vd[w] : 40'h0;
      in_amt = (w < 5) ? va[w] : 6'd0;
      #1;
      if (cyc == 5) begin
        checks++;
        if (w != 3) $display("[TB] FAIL bp_accepted: got %0d expected 3", w);
        else passed++;
        checks++;
        if (in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready: got %b expected 0", in_ready);
        else passed++;
        checks++;
        if (out_valid !== 1'b1) $display("[TB] FAIL bp_out_valid: got %b expected 1", out_valid);
        else passed++;
      end
      if (out_valid && !out_ready && out_data !== ve[0]) stable = 1'b0;
      if (out_valid && out_ready) begin
        checks++;
        if (rcv >= 5 || out_data !== ve[rcv])
          $display("[TB] FAIL bp_order[%0d]: got %h expected %h", rcv, out_data, (rcv < 5) ? ve[rcv] : 40'hx);
        else passed++;
        rcv++;
      end
      if (in_valid && in_ready) w++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (stable !== 1'b1) $display("[TB] FAIL bp_hold_stable: got %b expected 1", stable);
    else passed++;
    checks++;
    if (cyc != 11) $display("[TB] FAIL bp_drain_cycles: got %0d expected 11", cyc);
    else passed++;
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL bp_no_duplicate: got %b expected 0", out_valid);
    else passed++;
  endtask

  task automatic test_flush();
    int acc, cyc, lat;
    logic seen;
    logic [WIDTH-1:0] got;
    acc = 0; cyc = 0; seen = 1'b0;
    out_ready = 1'b0;
    while (acc < 3 && cyc < 20) begin
      in_valid = 1'b1;
      in_data = 40'h11_2233_4455 + 40'(acc);
      in_amt = 6'(acc);
      #1;
      if (in_ready) acc++;
      tick();
      cyc++;
    end
    checks++;
    if (out_valid !== 1'b1) $display("[TB] FAIL flush_pre_valid: got %b expected 1", out_valid);
    else passed++;
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 40'hDE_ADBE_EF00;
    in_amt = 6'd0;
    #1;
    checks++;
    if (in_ready !== 1'b0) $display("[TB] FAIL flush_in_ready: got %b expected 0", in_ready);
    else passed++;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL flush_out_valid: got %b expected 0", out_valid);
    else passed++;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) $display("[TB] FAIL flush_leak: got %b expected 0", seen);
    else passed++;
    send_one(40'h00_0000_0003, 6'd2, lat, got);
    checks++;
    if (lat != 3) $display("[TB] FAIL flush_after_latency: got %0d expected 3", lat);
    else passed++;
    checks++;
    if (got !== 40'h00_0000_000C) $display("[TB] FAIL flush_after_data: got %h expected %h", got, 40'h00_0000_000C);
    else passed++;
  endtask

  task automatic test_async_reset();
    int lat;
    logic [WIDTH-1:0] got;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = 40'hAB_CDEF_0123;
      in_amt = 6'd0;
      tick();
    end
    checks++;
    if (out_valid !== 1'b1) $display("[TB] FAIL areset_pre_valid: got %b expected 1", out_valid);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL areset_out_valid: got %b expected 0", out_valid);
    else passed++;
    checks++;
    if (out_data !== 40'h0) $display("[TB] FAIL areset_out_data: got %h expected 0", out_data);
    else passed++;
    checks++;
    if (in_ready !== 1'b0) $display("[TB] FAIL areset_in_ready: got %b expected 0", in_ready);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL areset_release_ready: got %b expected 1", in_ready);
    else passed++;
    send_one(40'h00_0000_0101, 6'd4, lat, got);
    checks++;
    if (lat != 3) $display("[TB] FAIL areset_after_latency: got %0d expected 3", lat);
    else passed++;
    checks++;
    if (got !== 40'h00_0000_1010) $display("[TB] FAIL areset_after_data: got %h expected %h", got, 40'h00_0000_1010);
    else passed++;
  endtask

`ifdef CIRC_UNSHIFT_TAG_EN
  task automatic test_tags();
    logic [WIDTH-1:0] exp_d [6];
    int sent, rcv, cyc;
    sent = 0; rcv = 0; cyc = 0;
    while (rcv < 6 && cyc < 300) begin
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 6) begin
        in_valid = 1'b1;
        in_tag = 6'(sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (rcv >= 6 || out_tag !== 6'(rcv))
          $display("[TB] FAIL tag_seq[%0d]: got %0d expected %0d", rcv, out_tag, rcv);
        else passed++;
        checks++;
        if (rcv >= 6 || out_data !== exp_d[rcv])
          $display("[TB] FAIL tag_data[%0d]: got %h expected %h", rcv, out_data, (rcv < 6) ? exp_d[rcv] : 40'hx);
        else passed++;
        rcv++;
      end
      if (in_valid && in_ready) begin
        exp_d[sent] = rotl_model(in_data, in_amt);
        sent++;
        in_data = {8'($urandom), 32'($urandom)};
        in_amt = 6'($urandom);
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (rcv != 6) $display("[TB] FAIL tag_count: got %0d expected 6", rcv);
    else passed++;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_amt = '0;
    out_ready = 1'b0;
`ifdef CIRC_UNSHIFT_TAG_EN
    in_tag = '0;
`endif
    test_reset();
    test_basic_rotate();
    test_round_trip();
    test_backpressure();
    test_flush();
    test_async_reset();
`ifdef CIRC_UNSHIFT_TAG_EN
    in_data = 40'h12_3456_789A;
    in_amt = 6'd17;
    test_tags();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/circular_barrel_unshift_pipe.md
Name: circular_barrel_unshift_pipe

Overview:
- Pipelined, flow-controlled circular left-rotator.
- Exact inverse of the 40-bit circular right-rotate used for lane and slot alignment: rotating right by N and then through this block by N returns the original word.
- Sits between alignment logic and consumers that need data restored to natural lane order.
- Three register stages with valid/ready handshake, stall propagation and synchronous flush.

Parameters:
- WIDTH, 40: data width in bits.
- AMT_W, 6: shift-amount width in bits.
- TAG_W, 6: sideband tag width; used only when the optional feature is enabled.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all pipeline contents.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts input this cycle.
- in_data  in  WIDTH  word to rotate.
- in_amt  in  AMT_W  left-rotate amount.
- in_tag  in  TAG_W  sideband tag; present only with CIRC_UNSHIFT_TAG_EN.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  rotated word.
- out_tag  out  TAG_W  tag aligned with out_data; present only with CIRC_UNSHIFT_TAG_EN.

Behaviour:
- Function: out_data = in_data rotated left by (in_amt mod WIDTH).
  - Bit i of in_data moves to bit (i + amt) mod WIDTH.
  - in_amt >= WIDTH is legal and wraps, e.g. amt 40 is identity and amt 63 equals amt 23.
- Decomposition: each in_amt bit k selects a rotate-left by (2^k mod WIDTH).
  - Stage 1 applies bits [1:0].
  - Stage 2 applies bits [3:2].
  - Stage 3 applies bits [5:4] and drives out_data.
  - Each stage registers its partial data, the remaining amount bits, valid and tag.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stage advance: stage n loads from stage n-1 when stage n is empty or stage n is being drained in the same cycle (ripple-ready).
  - in_ready = !s1_valid || s1 advances this cycle.
  - Combinational path from out_ready to in_ready is allowed.
- Latency and throughput: with out_ready held high, latency is exactly 3 cycles and throughput is 1 word per cycle.
- Full pipeline: all 3 stages valid with out_ready low gives in_ready low. No data is lost or overwritten, and order is preserved.
- Empty pipeline: out_valid low; out_data holds its last value and is don't-care.
- Output hold: out_data and out_tag hold stable while out_valid && !out_ready.
- flush:
  - Next cycle, all stage valids are 0.
  - An input presented in the flush cycle is dropped. in_ready is forced low during flush.
  - Data registers are not cleared.
  - Flush takes priority over every simultaneous transfer.
- Reset (asynchronous, rst_n low):
  - All valids, out_valid and out_data clear to 0 immediately, including mid-operation. out_tag clears to 0 when present.
  - in_ready is 0 while rst_n is low and 1 in the first cycle after release.
- Simultaneous events: when stage 3 drains and a new input enters stage 1 in the same cycle, all stages shift with no bubble.

Optional Feature:
- Macro: CIRC_UNSHIFT_TAG_EN.
- Defined:
  - in_tag and out_tag exist.
  - The tag is carried unmodified through all three stages alongside its data.
  - Tag registers reset to 0.
- Undefined:
  - No tag ports and no tag registers.
  - All other behaviour is identical.

Test Plan:
- Basic rotate, out_ready=1:
  - in_data=40'h00_0000_0001, amt=1 -> out_data=40'h00_0000_0002 exactly 3 cycles later.
  - amt=39 -> 40'h80_0000_0000.
- Wrap and modulo: in_data=40'h00_0000_0001.
  - amt=40 -> 40'h00_0000_0001.
  - amt=63 -> 40'h00_0080_0000.
  - amt=0 with in_data=40'hA5_5A5A_A55A -> output unchanged.
- Round trip: 1000 random (data, amt) pairs. Right-rotate data by amt in the bench model, feed through the block with the same amt -> output equals the original data on every transfer.
- Backpressure:
  - out_ready=0 for 6 cycles while driving 5 consecutive words -> in_ready drops after 3 accepted, out_data stable.
  - Release -> remaining words emerge in order, one per cycle, none lost or duplicated.
- Flush and reset:
  - Assert flush with 3 words in flight -> next cycle out_valid=0 and no flushed word appears later.
  - Drop rst_n asynchronously mid-stream -> out_valid=0 and out_data=0 immediately.
  - After release -> first new word has 3-cycle latency.
- With CIRC_UNSHIFT_TAG_EN: tags 0..5 sent with random data under random out_ready -> out_tag sequence 0..5 matches each word's data.
